// File: rtl/traffic_pkg.sv
// Shared types and helpers for the intersection phase controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GREEN   = 2'd1,
    YELLOW  = 2'd2,
    ALL_RED = 2'd3
  } state_t;

  // Phase timer width: enough bits to count the longest phase, plus one spare bit.
  function automatic int timer_width(input int green_cyc, input int jam_cyc,
                                     input int yellow_cyc, input int red_cyc);
    int m;
    m = green_cyc;
    if (jam_cyc > m)    m = jam_cyc;
    if (yellow_cyc > m) m = yellow_cyc;
    if (red_cyc > m)    m = red_cyc;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/traffic_phase_ctrl_rr_jam_select.sv
// Next-approach selector: the first jammed approach in cyclic order after ptr
// (ptr itself is checked last), or plain round-robin when nothing is jammed.
module rr_jam_select #(
  parameter int N_DIR = 4
) (
  input  logic [$clog2(N_DIR)-1:0] ptr,
  input  logic [N_DIR-1:0]         jam_sensor,
  output logic [$clog2(N_DIR)-1:0] sel_dir,
  output logic                     sel_jam
);
  localparam int DW = $clog2(N_DIR);

  // Walk the search order backwards so the earliest jammed candidate wins.
  always_comb begin
    int          idx;
    logic [DW-1:0] cand;
    idx = int'(ptr) + 1;
    if (idx >= N_DIR) idx = idx - N_DIR;
    sel_dir = DW'(idx);
    sel_jam = 1'b0;
    for (int i = N_DIR; i >= 1; i--) begin
      idx = int'(ptr) + i;
      if (idx >= N_DIR) idx = idx - N_DIR;
      cand = DW'(idx);
      if (jam_sensor[cand]) begin
        sel_dir = cand;
        sel_jam = 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Self-timed intersection phase controller: round-robin green/yellow/all-red
// sequencing with jam pre-emption after a minimum green. All outputs registered.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int N_DIR         = 4,
  parameter int GREEN_CYC     = 8,
  parameter int JAM_GREEN_CYC = 12,
  parameter int MIN_GREEN     = 3,
  parameter int YELLOW_CYC    = 2,
  parameter int RED_CYC       = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_DIR-1:0]         jam_sensor,
  output logic [N_DIR-1:0]         allow,
  output logic [N_DIR-1:0]         yellow,
  output logic [$clog2(N_DIR)-1:0] active_dir,
  output logic                     jam_mode
);
  localparam int DW = $clog2(N_DIR);
  localparam int TW = timer_width(GREEN_CYC, JAM_GREEN_CYC, YELLOW_CYC, RED_CYC);

  localparam logic [TW-1:0] T_GREEN_END  = TW'(GREEN_CYC - 1);
  localparam logic [TW-1:0] T_JAM_END    = TW'(JAM_GREEN_CYC - 1);
  localparam logic [TW-1:0] T_MIN_END    = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] T_YELLOW_END = TW'(YELLOW_CYC - 1);
  localparam logic [TW-1:0] T_RED_END    = TW'(RED_CYC - 1);

  state_t        state;
  logic [TW-1:0] timer;
  logic [DW-1:0] ptr;
  logic [DW-1:0] sel_dir;
  logic          sel_jam;
  logic          limit_hit;
  logic          min_met;
  logic          other_jam;
  logic          green_exit;

  function automatic logic [N_DIR-1:0] dir_mask(input logic [DW-1:0] d);
    logic [N_DIR-1:0] m;
    m    = '0;
    m[d] = 1'b1;
    return m;
  endfunction

  // Before the first grant the search starts behind approach 0.
  assign ptr = (state == IDLE) ? DW'(N_DIR - 1) : active_dir;

  rr_jam_select #(.N_DIR(N_DIR)) u_sel (
    .ptr        (ptr),
    .jam_sensor (jam_sensor),
    .sel_dir    (sel_dir),
    .sel_jam    (sel_jam)
  );

  // Green ends at its time limit, or early once the minimum green has elapsed:
  // normal green yields to a jam elsewhere, jam green ends when its jam clears.
  assign limit_hit  = jam_mode ? (timer == T_JAM_END) : (timer == T_GREEN_END);
  assign min_met    = (timer >= T_MIN_END);
  assign other_jam  = |(jam_sensor & ~dir_mask(active_dir));
  assign green_exit = limit_hit ||
                      (min_met && (jam_mode ? !jam_sensor[active_dir] : other_jam));

  // Phase FSM with timer and registered light outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      timer      <= '0;
      active_dir <= '0;
      jam_mode   <= 1'b0;
      allow      <= '0;
      yellow     <= '0;
    end else begin
      case (state)
        IDLE: begin
          state      <= GREEN;
          timer      <= '0;
          active_dir <= sel_dir;
          jam_mode   <= sel_jam;
          allow      <= dir_mask(sel_dir);
          yellow     <= '0;
        end
        GREEN: begin
          if (green_exit) begin
            state  <= YELLOW;
            timer  <= '0;
            allow  <= '0;
            yellow <= dir_mask(active_dir);
          end else begin
            timer <= timer + 1'b1;
          end
        end
        YELLOW: begin
          if (timer == T_YELLOW_END) begin
            state  <= ALL_RED;
            timer  <= '0;
            yellow <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ALL_RED: begin
          if (timer == T_RED_END) begin
            state      <= GREEN;
            timer      <= '0;
            active_dir <= sel_dir;
            jam_mode   <= sel_jam;
            allow      <= dir_mask(sel_dir);
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          timer  <= '0;
          allow  <= '0;
          yellow <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: directed vector tables, an async reset
// sequence, and random jam traffic against a phase-schedule reference model.
module tb_traffic_phase_ctrl;
  localparam int N     = 4;
  localparam int GRN   = 8;
  localparam int JGRN  = 12;
  localparam int MING  = 3;
  localparam int YEL   = 2;
  localparam int RED   = 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] jam_sensor = '0;
  logic [N-1:0] allow;
  logic [N-1:0] yellow;
  logic [1:0]   active_dir;
  logic         jam_mode;

  int n_checks = 0;
  int n_fail   = 0;

  traffic_phase_ctrl #(
    .N_DIR(N), .GREEN_CYC(GRN), .JAM_GREEN_CYC(JGRN),
    .MIN_GREEN(MING), .YELLOW_CYC(YEL), .RED_CYC(RED)
  ) dut (
    .clk(clk), .rst_n(rst_n), .jam_sensor(jam_sensor),
    .allow(allow), .yellow(yellow), .active_dir(active_dir), .jam_mode(jam_mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] jam;
    logic [3:0] allow;
    logic [3:0] yel;
    logic [1:0] dir;
    logic       jm;
  } vec_t;

  vec_t tbl[$];

  // Reference model: a grant is (dir, jam flag, age since grant); green length
  // is unknown (-1) until the exit decision, after which yellow and red follow.
  bit m_idle;
  int m_dir;
  bit m_jm;
  int m_age;
  int m_glen;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, k, act, exp);
    end
  endtask

  task automatic model_reset();
    m_idle = 1'b1; m_dir = 0; m_jm = 1'b0; m_age = 0; m_glen = -1;
  endtask

  task automatic model_grant(input int p, input logic [3:0] j);
    int found;
    found = -1;
    for (int i = 1; i <= N; i++)
      if (found < 0 && j[(p + i) % N]) found = (p + i) % N;
    if (found >= 0) begin m_dir = found; m_jm = 1'b1; end
    else begin m_dir = (p + 1) % N; m_jm = 1'b0; end
    m_age = 0; m_glen = -1;
  endtask

  task automatic model_step(input logic [3:0] j);
    int  lim;
    bit  early;
    if (m_idle) begin
      m_idle = 1'b0;
      model_grant(N - 1, j);
      return;
    end
    if (m_glen < 0) begin
      lim = m_jm ? JGRN : GRN;
      if (m_jm) early = (j[m_dir] == 1'b0);
      else      early = ((int'(j) & ~(1 << m_dir)) != 0);
      if (m_age + 1 == lim || (m_age + 1 >= MING && early)) m_glen = m_age + 1;
    end
    m_age++;
    if (m_glen >= 0 && m_age == m_glen + YEL + RED) model_grant(m_dir, j);
  endtask

  task automatic model_check(input int k);
    logic [3:0] ea, ey;
    ea = '0; ey = '0;
    if (!m_idle) begin
      if (m_glen < 0)                ea = 4'(1 << m_dir);
      else if (m_age - m_glen < YEL) ey = 4'(1 << m_dir);
    end
    chk("model_allow",  k, 32'(allow),      32'(ea));
    chk("model_yellow", k, 32'(yellow),     32'(ey));
    chk("model_dir",    k, 32'(active_dir), m_idle ? 32'd0 : 32'(m_dir));
    chk("model_jam",    k, 32'(jam_mode),   m_idle ? 32'd0 : 32'(m_jm));
    chk("inv_exclusive", k, 32'((|allow) && (|yellow)), 32'd0);
    chk("inv_onehot0",   k, 32'($onehot0(allow) && $onehot0(yellow)), 32'd1);
  endtask

  task automatic add(input int c, input logic [3:0] j, input logic [3:0] a,
                     input logic [3:0] y, input logic [1:0] d, input logic jm);
    vec_t v;
    v.cyc = c; v.jam = j; v.allow = a; v.yel = y; v.dir = d; v.jm = jm;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    jam_sensor = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  // Cycle k is sampled on the negedge before the k-th rising edge after
  // release; a table entry's jam is driven from that cycle onward.
  task automatic run_table(input string nm);
    int e;
    int last;
    e = 0;
    last = tbl[tbl.size() - 1].cyc;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      model_check(k);
      if (e < tbl.size() && tbl[e].cyc == k) begin
        chk({nm, "_allow"},  k, 32'(allow),      32'(tbl[e].allow));
        chk({nm, "_yellow"}, k, 32'(yellow),     32'(tbl[e].yel));
        chk({nm, "_dir"},    k, 32'(active_dir), 32'(tbl[e].dir));
        chk({nm, "_jam"},    k, 32'(jam_mode),   32'(tbl[e].jm));
        jam_sensor = tbl[e].jam;
        e++;
      end
      @(posedge clk);
      model_step(jam_sensor);
    end
  endtask

  task automatic load_case1(input int upto);
    tbl.delete();
    add(0,  4'h0, 4'h0, 4'h0, 2'd0, 1'b0);
    add(1,  4'h0, 4'h1, 4'h0, 2'd0, 1'b0);
    add(8,  4'h0, 4'h1, 4'h0, 2'd0, 1'b0);
    add(9,  4'h0, 4'h0, 4'h1, 2'd0, 1'b0);
    if (upto > 9) begin
      add(10, 4'h0, 4'h0, 4'h1, 2'd0, 1'b0);
      add(11, 4'h0, 4'h0, 4'h0, 2'd0, 1'b0);
      add(12, 4'h0, 4'h2, 4'h0, 2'd1, 1'b0);
      add(23, 4'h0, 4'h4, 4'h0, 2'd2, 1'b0);
      add(34, 4'h0, 4'h8, 4'h0, 2'd3, 1'b0);
      add(45, 4'h0, 4'h1, 4'h0, 2'd0, 1'b0);
      add(50, 4'h0, 4'h1, 4'h0, 2'd0, 1'b0);
    end
  endtask

  initial begin
    // Case 1: plain rotation.
    do_reset();
    load_case1(50);
    run_table("rotate");

    // Cases 2 and 3: jam pre-empts after minimum green, then releases.
    do_reset();
    tbl.delete();
    add(0,  4'h0, 4'h0, 4'h0, 2'd0, 1'b0);
    add(2,  4'h4, 4'h1, 4'h0, 2'd0, 1'b0);
    add(3,  4'h4, 4'h1, 4'h0, 2'd0, 1'b0);
    add(4,  4'h4, 4'h0, 4'h1, 2'd0, 1'b0);
    add(5,  4'h4, 4'h0, 4'h1, 2'd0, 1'b0);
    add(6,  4'h4, 4'h0, 4'h0, 2'd0, 1'b0);
    add(7,  4'h4, 4'h4, 4'h0, 2'd2, 1'b1);
    add(9,  4'h4, 4'h4, 4'h0, 2'd2, 1'b1);
    add(10, 4'h0, 4'h4, 4'h0, 2'd2, 1'b1);
    add(11, 4'h0, 4'h0, 4'h4, 2'd2, 1'b1);
    add(12, 4'h0, 4'h0, 4'h4, 2'd2, 1'b1);
    add(13, 4'h0, 4'h0, 4'h0, 2'd2, 1'b1);
    add(14, 4'h0, 4'h8, 4'h0, 2'd3, 1'b0);
    run_table("jam_release");

    // Case 4: two jams, search continues after the current approach.
    do_reset();
    tbl.delete();
    add(0,  4'h0, 4'h0, 4'h0, 2'd0, 1'b0);
    add(2,  4'h2, 4'h1, 4'h0, 2'd0, 1'b0);
    add(4,  4'h2, 4'h0, 4'h1, 2'd0, 1'b0);
    add(7,  4'hA, 4'h2, 4'h0, 2'd1, 1'b1);
    add(18, 4'hA, 4'h2, 4'h0, 2'd1, 1'b1);
    add(19, 4'hA, 4'h0, 4'h2, 2'd1, 1'b1);
    add(21, 4'hA, 4'h0, 4'h0, 2'd1, 1'b1);
    add(22, 4'hA, 4'h8, 4'h0, 2'd3, 1'b1);
    add(33, 4'hA, 4'h8, 4'h0, 2'd3, 1'b1);
    add(34, 4'hA, 4'h0, 4'h8, 2'd3, 1'b1);
    add(37, 4'hA, 4'h2, 4'h0, 2'd1, 1'b1);
    run_table("dual_jam");

    // Case 5: a lone persistent jam is re-granted every 15 cycles.
    do_reset();
    tbl.delete();
    add(0,  4'h1, 4'h0, 4'h0, 2'd0, 1'b0);
    add(1,  4'h1, 4'h1, 4'h0, 2'd0, 1'b1);
    add(12, 4'h1, 4'h1, 4'h0, 2'd0, 1'b1);
    add(13, 4'h1, 4'h0, 4'h1, 2'd0, 1'b1);
    add(15, 4'h1, 4'h0, 4'h0, 2'd0, 1'b1);
    add(16, 4'h1, 4'h1, 4'h0, 2'd0, 1'b1);
    add(27, 4'h1, 4'h1, 4'h0, 2'd0, 1'b1);
    add(28, 4'h1, 4'h0, 4'h1, 2'd0, 1'b1);
    add(31, 4'h1, 4'h1, 4'h0, 2'd0, 1'b1);
    run_table("solo_jam");

    // Case 6: asynchronous reset in the middle of yellow.
    do_reset();
    load_case1(9);
    run_table("pre_reset");
    #1 chk("mid_yellow", 10, 32'(yellow), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_allow",  10, 32'(allow),      32'h0);
    chk("async_yellow", 10, 32'(yellow),     32'h0);
    chk("async_dir",    10, 32'(active_dir), 32'h0);
    chk("async_jam",    10, 32'(jam_mode),   32'h0);
    do_reset();
    load_case1(50);
    run_table("after_reset");

    // Random jam traffic against the model.
    do_reset();
    for (int k = 0; k < 800; k++) begin
      int r;
      @(negedge clk);
      model_check(k);
      r = int'($urandom_range(0, 11));
      if (r == 0)      jam_sensor = 4'($urandom);
      else if (r <= 2) jam_sensor = '0;
      else if (r == 3) jam_sensor = 4'(1 << $urandom_range(0, 3));
      @(posedge clk);
      model_step(jam_sensor);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
